seg_display_scanner: RTL and testbench
======================================

# seg_display_scanner

Board-side display and stepping front end for the multi-cycle CPU top. It reads the four 16-bit debug words the CPU exports (PC pair, RS pair, RT pair, ALU/DB pair) and shows the word chosen by two switches on a 4-digit common-anode 7-segment display using time-multiplexed scanning. It also debounces the push button that single-steps the CPU and drives the CPU's negative-pulse clock input from it.

## Interface
Parameters:
- SCAN_DIV, default 100000: CLK cycles each digit stays lit; legal range ≥2.
- DEBOUNCE_CYCLES, default 1000000: consecutive CLK cycles the synchronized button must hold a new level before it is accepted; legal range ≥2.

Ports:
- CLK, input, 1: board clock. All state updates on its rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- sign1, input, 16: PC word, {current PC[7:0], next PC[7:0]}.
- sign2, input, 16: RS word.
- sign3, input, 16: RT word.
- sign4, input, 16: ALU/DB word.
- SW, input, 2: word select. 00 selects sign1, 01 sign2, 10 sign3, 11 sign4.
- BTN, input, 1: raw step button, high while pressed, asynchronous to CLK.
- CPU_CLK, output, 1: step clock to the CPU. Idle high; low while the debounced button is pressed.
- step_pulse, output, 1: one-CLK-cycle strobe on each debounced press.
- AN, output, 4: digit anodes, active-low. AN[0] is the rightmost digit.
- SEG, output, 8: active-low segments. SEG[7] is DP; SEG[6:0] is {g,f,e,d,c,b,a}.

## Operation
Scan path:
- scan_cnt counts 0..SCAN_DIV-1. On wrap, the digit index idx (2 bits) increments modulo 4.
- The value word is the input selected by SW and is sampled every cycle, unless SEG_FRAME_LATCH_EN is defined (see Configuration).
- Digit idx shows nibble word[4*idx+3 : 4*idx].
- AN is one-hot low on digit idx: idx 0 → 1110, 1 → 1101, 2 → 1011, 3 → 0111.
- Hex font, SEG[6:0] values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- DP (SEG[7]) stays 1 (off) except on digit 2 while the debounced button is held; that digit marks the byte boundary during a step.

Debounce path (sub-module btn_debounce):
- A 2-flop synchronizer on BTN produces btn_sync.
- db_cnt clears whenever btn_sync equals stable.
- Otherwise db_cnt increments; when it reaches DEBOUNCE_CYCLES-1, stable takes btn_sync and db_cnt clears.
- step_pulse = stable rose this cycle, registered.
- CPU_CLK = ~stable, registered.
- A glitch shorter than DEBOUNCE_CYCLES is never accepted.

## Timing
Reset values, applied asynchronously:
- AN=1111 (all digits off), SEG=FF, idx=0, scan_cnt=0.
- Both synchronizer flops = 0, stable=0, db_cnt=0.
- step_pulse=0, CPU_CLK=1.

Scan timing:
- AN and SEG are registered and update one CLK after idx or the value changes.
- The first edge after Reset deasserts loads AN=1110.
- Each digit is lit for exactly SCAN_DIV cycles, so a full frame is 4·SCAN_DIV cycles.
- An SW change mid-digit takes effect on the next cycle (live mode).

Debounce timing:
- BTN-to-stable latency is 2 synchronizer cycles plus DEBOUNCE_CYCLES cycles, plus 1 cycle to reach step_pulse and CPU_CLK.
- A press and a release each require the full debounce window.
- Reset asserted mid-count or mid-press forces CPU_CLK high immediately, with no step_pulse.
- Count wrap: scan_cnt and db_cnt never exceed their terminal values. Counter widths are $clog2 of the parameter.

## Configuration
SEG_FRAME_LATCH_EN:
- Defined: a frame register captures the SW-selected word on the cycle idx wraps 3→0, and on the first cycle after reset. All four digits of a frame then come from one snapshot, so a CPU step or SW change mid-frame never tears the display.
- Undefined: there is no frame register and digits read the selected word live.

## Structure
- Shared package seg_pkg holds:
  - the 16-entry hex font constant array;
  - the anode pattern constants;
  - the SW select encodings.
- Sub-module btn_debounce contains the synchronizer, db_cnt, stable, step_pulse and CPU_CLK. It is parameterized by DEBOUNCE_CYCLES.
- The top holds the scan counter, the mux, the optional frame register and the output registers.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
1. Reset pulse mid-scan → AN=1111, SEG=FF and CPU_CLK=1 immediately. First edge after release → AN=1110.
2. SW=00, sign1=1234 → over one 16-cycle frame, AN/SEG[6:0] sequence is 1110/19, 1101/30, 1011/24, 0111/79, each held 4 cycles.
3. SW=11, sign4=ABCF → digits show F, C, b, A (0E, 46, 03, 08). Switch SW to 01 with sign2=0000 mid-digit → the next cycle shows 40 (live build).
4. BTN high for 5 cycles then low → no step_pulse and CPU_CLK stays 1. BTN high for 20 cycles → exactly one step_pulse at cycle 11 after the press, CPU_CLK low until release plus 11 cycles.
5. SEG_FRAME_LATCH_EN defined: change sign1 from 1234 to 5678 while idx=1 → the rest of the frame shows 2, 1; the next frame shows 8, 7, 6, 5.
6. Hold the button and check digit 2: SEG[7]=0 only while AN=1011 and stable=1. Everywhere else SEG[7]=1.

Source files
------------

// File: rtl/seg_display_scanner_pkg.sv
// seg_pkg: hex font, anode patterns and word-select encodings for the display scanner
package seg_pkg;
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [1:0] SW_PC  = 2'b00;
  localparam logic [1:0] SW_RS  = 2'b01;
  localparam logic [1:0] SW_RT  = 2'b10;
  localparam logic [1:0] SW_ALU = 2'b11;
endpackage

// File: rtl/seg_display_scanner_btn_debounce.sv
// btn_debounce: synchronizes and debounces the step button, drives the CPU step clock
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_stable,
  output logic o_step_pulse,
  output logic o_cpu_clk
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_stable, r_step, r_cpu_clk;
  logic w_diff, w_done;
  always_comb begin
    w_diff = r_sync[1] != r_stable;
    w_done = r_cnt == LAST;
  end
  // r_cpu_clk holds ~stable of the previous cycle, so it doubles as the edge detector
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync    <= 2'b00;
      r_cnt     <= '0;
      r_stable  <= 1'b0;
      r_step    <= 1'b0;
      r_cpu_clk <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_cnt     <= (!w_diff || w_done) ? '0 : r_cnt + CW'(1);
      if (w_diff && w_done) r_stable <= r_sync[1];
      r_step    <= r_stable & r_cpu_clk;
      r_cpu_clk <= ~r_stable;
    end
  assign o_stable     = r_stable;
  assign o_step_pulse = r_step;
  assign o_cpu_clk    = r_cpu_clk;
endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: 4-digit hex scan of a selected CPU debug word plus step-button front end.
// Define SEG_FRAME_LATCH_EN to snapshot the word once per frame instead of reading it live.
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] sign1,
  input  logic [15:0] sign2,
  input  logic [15:0] sign3,
  input  logic [15:0] sign4,
  input  logic [1:0]  SW,
  input  logic        BTN,
  output logic        CPU_CLK,
  output logic        step_pulse,
  output logic [3:0]  AN,
  output logic [7:0]  SEG
);
  localparam int SW_W = $clog2(SCAN_DIV);
  localparam logic [SW_W-1:0] LAST = SW_W'(SCAN_DIV - 1);
  logic [SW_W-1:0] r_cnt;
  logic [1:0] r_idx;
  logic [3:0] r_an;
  logic [7:0] r_seg;
  logic [15:0] w_sel, w_word;
  logic [3:0] w_nib;
  logic w_stable;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(CLK), .rst(Reset), .i_btn(BTN),
    .o_stable(w_stable), .o_step_pulse(step_pulse), .o_cpu_clk(CPU_CLK)
  );
`ifdef SEG_FRAME_LATCH_EN
  logic [15:0] r_frame;
  logic r_first;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      r_frame <= '0;
      r_first <= 1'b1;
    end else begin
      if (r_first || (r_cnt == LAST && r_idx == 2'd3)) r_frame <= w_sel;
      r_first <= 1'b0;
    end
  // bypass on the first cycle so digit 0 of the first frame is not stale
  assign w_word = r_first ? w_sel : r_frame;
`else
  assign w_word = w_sel;
`endif
  always_comb begin
    w_sel = SW == SW_PC ? sign1 : SW == SW_RS ? sign2 : SW == SW_RT ? sign3 : sign4;
    w_nib = w_word[{r_idx, 2'b00} +: 4];
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
      r_an  <= AN_OFF;
      r_seg <= 8'hFF;
    end else begin
      r_cnt <= r_cnt == LAST ? '0 : r_cnt + SW_W'(1);
      if (r_cnt == LAST) r_idx <= r_idx + 2'd1;
      r_an  <= AN_PAT[r_idx];
      r_seg <= {~(r_idx == 2'd2 && w_stable), FONT[w_nib]};
    end
  assign AN  = r_an;
  assign SEG = r_seg;
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: directed checks of scan, select, debounce and DP with SCAN_DIV=4, DEBOUNCE_CYCLES=8
module tb_seg_display_scanner;
  logic CLK = 1'b0, Reset = 1'b1, BTN = 1'b0;
  logic [15:0] sign1 = '0, sign2 = '0, sign3 = '0, sign4 = '0;
  logic [1:0] SW = 2'b00;
  logic CPU_CLK, step_pulse;
  logic [3:0] AN;
  logic [7:0] SEG;
  int tests = 0, fails = 0;
  localparam logic [3:0] AN_EXP [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  seg_display_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .CLK(CLK), .Reset(Reset), .sign1(sign1), .sign2(sign2), .sign3(sign3), .sign4(sign4),
    .SW(SW), .BTN(BTN), .CPU_CLK(CPU_CLK), .step_pulse(step_pulse), .AN(AN), .SEG(SEG)
  );
  always #5 CLK = ~CLK;
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset;
    Reset = 1'b1;
    step;
    step;
    Reset = 1'b0;
  endtask
  task automatic test_reset;
    SW = 2'b00;
    sign1 = 16'h1234;
    do_reset;
    repeat (6) step;
    Reset = 1'b1;
    #1;
    tests++;
    if (AN !== 4'b1111) begin fails++; $display("FAIL reset_an: got %b want 1111", AN); end
    tests++;
    if (SEG !== 8'hFF) begin fails++; $display("FAIL reset_seg: got %h want ff", SEG); end
    tests++;
    if (CPU_CLK !== 1'b1 || step_pulse !== 1'b0) begin
      fails++; $display("FAIL reset_clk: got cpu_clk=%b pulse=%b want 1 0", CPU_CLK, step_pulse);
    end
    step;
    Reset = 1'b0;
    step;
    tests++;
    if (AN !== 4'b1110) begin fails++; $display("FAIL first_an: got %b want 1110", AN); end
    tests++;
    if (SEG !== 8'h99) begin fails++; $display("FAIL first_seg: got %h want 99", SEG); end
  endtask
  task automatic test_scan_pc;
    logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    SW = 2'b00;
    sign1 = 16'h1234;
    do_reset;
    for (int k = 0; k < 16; k++) begin
      step;
      tests++;
      if (AN !== AN_EXP[k/4] || SEG !== {1'b1, exp_seg[k/4]}) begin
        fails++;
        $display("FAIL scan_pc[%0d]: got %b/%h want %b/%h", k, AN, SEG, AN_EXP[k/4], {1'b1, exp_seg[k/4]});
      end
    end
  endtask
  task automatic test_select_live;
    logic [6:0] exp_seg [4] = '{7'h0E, 7'h46, 7'h03, 7'h08};
    logic [6:0] want;
    SW = 2'b11;
    sign4 = 16'hABCF;
    sign2 = 16'h0000;
    do_reset;
    for (int k = 0; k < 16; k++) begin
      step;
      tests++;
      if (AN !== AN_EXP[k/4] || SEG[6:0] !== exp_seg[k/4]) begin
        fails++;
        $display("FAIL scan_alu[%0d]: got %b/%h want %b/%h", k, AN, SEG[6:0], AN_EXP[k/4], exp_seg[k/4]);
      end
    end
    step;
    step;
    SW = 2'b01;
    step;
`ifdef SEG_FRAME_LATCH_EN
    want = 7'h0E;
`else
    want = 7'h40;
`endif
    tests++;
    if (SEG[6:0] !== want || AN !== 4'b1110) begin
      fails++; $display("FAIL sw_switch: got %b/%h want 1110/%h", AN, SEG[6:0], want);
    end
  endtask
  task automatic test_glitch;
    int pulses = 0, lows = 0;
    do_reset;
    BTN = 1'b1;
    repeat (5) step;
    BTN = 1'b0;
    repeat (25) begin
      step;
      if (step_pulse !== 1'b0) pulses++;
      if (CPU_CLK !== 1'b1) lows++;
    end
    tests++;
    if (pulses != 0) begin fails++; $display("FAIL glitch_pulse: got %0d pulses want 0", pulses); end
    tests++;
    if (lows != 0) begin fails++; $display("FAIL glitch_cpu_clk: got %0d low cycles want 0", lows); end
  endtask
  task automatic test_press;
    logic exp_p, exp_c;
    do_reset;
    BTN = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step;
      exp_p = (k == 11);
      exp_c = !(k >= 11 && k <= 30);
      tests++;
      if (step_pulse !== exp_p || CPU_CLK !== exp_c) begin
        fails++;
        $display("FAIL press[%0d]: got pulse=%b cpu_clk=%b want %b %b", k, step_pulse, CPU_CLK, exp_p, exp_c);
      end
      if (k == 20) BTN = 1'b0;
    end
  endtask
  task automatic test_dp;
    int d;
    int lit = 0;
    logic exp_dp;
    SW = 2'b00;
    sign1 = 16'h1234;
    Reset = 1'b1;
    step;
    Reset = 1'b0;
    BTN = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step;
      d = ((k - 1) / 4) % 4;
      exp_dp = !(d == 2 && k >= 11);
      if (!exp_dp) lit++;
      tests++;
      if (AN !== AN_EXP[d] || SEG[7] !== exp_dp) begin
        fails++;
        $display("FAIL dp[%0d]: got an=%b dp=%b want %b %b", k, AN, SEG[7], AN_EXP[d], exp_dp);
      end
    end
    tests++;
    if (CPU_CLK !== 1'b0) begin fails++; $display("FAIL held_cpu_clk: got %b want 0", CPU_CLK); end
    Reset = 1'b1;
    #1;
    tests++;
    if (CPU_CLK !== 1'b1 || step_pulse !== 1'b0 || SEG[7] !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_press: got cpu_clk=%b pulse=%b dp=%b want 1 0 1", CPU_CLK, step_pulse, SEG[7]);
    end
    BTN = 1'b0;
    step;
    Reset = 1'b0;
    if (lit == 0) $display("note: dp window empty");
  endtask
`ifdef SEG_FRAME_LATCH_EN
  task automatic test_frame_latch;
    logic [6:0] exp_seg [8] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h00, 7'h78, 7'h02, 7'h12};
    SW = 2'b00;
    sign1 = 16'h1234;
    do_reset;
    for (int k = 1; k <= 32; k++) begin
      step;
      if (k == 5) sign1 = 16'h5678;
      tests++;
      if (AN !== AN_EXP[((k-1)/4)%4] || SEG[6:0] !== exp_seg[(k-1)/4]) begin
        fails++;
        $display("FAIL frame[%0d]: got %b/%h want %b/%h", k, AN, SEG[6:0], AN_EXP[((k-1)/4)%4], exp_seg[(k-1)/4]);
      end
    end
  endtask
`endif
  initial begin
    test_reset;
    test_scan_pc;
    test_select_live;
    test_glitch;
    test_press;
    test_dp;
`ifdef SEG_FRAME_LATCH_EN
    test_frame_latch;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
